// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared constants and the {pc, inst} prefetch entry type for the fetch stage
package stage_if_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous prefetch FIFO of {pc, inst}; flush wins over push/pop
module if_fifo
  import stage_if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) r_mem[r_wr] <= din;
  end

  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign head  = r_mem[r_rd];

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - RV32I instruction fetch stage with prefetch FIFO and redirect discard tracking
// Optional perf counters (perf_fetch_o, perf_bubble_o) enabled by defining IF_PERF_CNT_EN.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_bubble_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  fetch_entry_t  w_head;
  fetch_entry_t  w_din;
  logic [SW-1:0] w_inflight;
  logic          w_grant;
  logic          w_drop;
  logic          w_keep;
  logic          w_push;
  logic          w_pop;

  // Every slot that a word could land in is reserved up front, so the FIFO never overflows.
  assign w_inflight = SW'(w_count) + SW'(r_outstanding) + SW'(r_discard);
  assign mem_req_o  = !rst && !branch_flag_i && !w_full && (w_inflight < SW'(FIFO_DEPTH));
  assign mem_addr_o = r_fetch_pc;

  assign w_grant = mem_req_o && mem_gnt_i;
  assign w_drop  = mem_rvalid_i && (r_discard != '0);
  assign w_keep  = mem_rvalid_i && (r_discard == '0) && (r_outstanding != '0);
  assign w_push  = w_keep && !branch_flag_i;
  assign w_pop   = inst_valid_o && !stall_i && !branch_flag_i;
  assign w_din   = '{pc: r_resp_pc, inst: mem_rdata_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (branch_flag_i) begin
      // Words still owed by memory for the old path become discards; a word arriving now is one of them.
      r_fetch_pc    <= branch_target_i;
      r_resp_pc     <= branch_target_i;
      r_outstanding <= '0;
      r_discard     <= r_discard + r_outstanding - CW'(w_drop || w_keep);
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_keep)  r_resp_pc  <= r_resp_pc + 32'd4;
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_keep);
      r_discard     <= r_discard - CW'(w_drop);
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (branch_flag_i),
    .din   (w_din),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full),
    .head  (w_head)
  );

  assign inst_valid_o = !w_empty;
  assign pc_o         = w_empty ? ZERO_WORD : w_head.pc;
  assign inst_o       = w_empty ? NOP_INST  : w_head.inst;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch  <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (w_pop)                    r_perf_fetch  <= r_perf_fetch + 32'd1;
      if (!inst_valid_o && !stall_i) r_perf_bubble <= r_perf_bubble + 32'd1;
    end
  end

  assign perf_fetch_o  = r_perf_fetch;
  assign perf_bubble_o = r_perf_bubble;
`endif

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - randomized self-checking bench for stage_if against a program-order fetch model
module tb_stage_if;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_bubble_o;
`endif

  stage_if #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_o    (perf_fetch_o),
    .perf_bubble_o   (perf_bubble_o)
`endif
  );

  always #5 clk = ~clk;

  // Memory requests in flight: drop = belongs to an abandoned path, counted = still known to the DUT.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          drop;
    bit          counted;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] fa = RESET_PC;
  logic [31:0] exp_pc = RESET_PC;
  int          occ = 0;
  int          n_pop = 0;
  int          n_bub = 0;
  int          total = 0;
  int          bad = 0;

  logic        s_valid, s_req;
  logic [31:0] s_pc, s_inst, s_addr, s_pf, s_pb;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic int live_pending();
    int n = 0;
    foreach (mq[i]) if (mq[i].counted) n++;
    return n;
  endfunction

  function automatic bit resp_now();
    return (mq.size() > 0) && (mq[0].due <= cyc);
  endfunction

  // One clock: drive at negedge, sample and check 1 time unit later, then advance the model.
  task automatic step(input bit r, input bit st, input bit br, input logic [31:0] tgt, input bit g);
    bit    exp_req, do_pop, do_push;
    mreq_t e;
    @(negedge clk);
    rst = r; stall_i = st; branch_flag_i = br; branch_target_i = tgt; mem_gnt_i = g;
    if (resp_now()) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = word_of(mq[0].addr);
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
    #1;
    s_valid = inst_valid_o; s_req = mem_req_o; s_pc = pc_o; s_inst = inst_o; s_addr = mem_addr_o;
`ifdef IF_PERF_CNT_EN
    s_pf = perf_fetch_o; s_pb = perf_bubble_o;
`else
    s_pf = '0; s_pb = '0;
`endif
    exp_req = !r && !br && (occ + live_pending() < DEPTH);
    total++;
    if (mem_req_o !== exp_req) begin
      bad++; $display("FAIL mem_req cyc=%0d got=%b exp=%b", cyc, mem_req_o, exp_req);
    end
    if (!r) begin
      if (exp_req) begin
        total++;
        if (mem_addr_o !== fa) begin
          bad++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr_o, fa);
        end
      end
      total++;
      if (inst_valid_o !== (occ > 0)) begin
        bad++; $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_o, occ > 0);
      end
      total++;
      if (occ > 0) begin
        if (pc_o !== exp_pc || inst_o !== word_of(exp_pc)) begin
          bad++; $display("FAIL head cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_o, inst_o, exp_pc, word_of(exp_pc));
        end
      end else if (pc_o !== 32'h0 || inst_o !== NOP) begin
        bad++; $display("FAIL empty_head cyc=%0d got=%h/%h exp=0/%h", cyc, pc_o, inst_o, NOP);
      end
`ifdef IF_PERF_CNT_EN
      total++;
      if (perf_fetch_o !== 32'(n_pop) || perf_bubble_o !== 32'(n_bub)) begin
        bad++; $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, perf_fetch_o, perf_bubble_o, n_pop, n_bub);
      end
`endif
    end
    do_push = 1'b0;
    if (mem_rvalid_i) begin
      e = mq.pop_front();
      do_push = !r && !br && !e.drop;
    end
    do_pop = !r && !br && (occ > 0) && !st;
    if (!r) begin
      if (!st && occ == 0) n_bub++;
      if (do_pop) n_pop++;
    end
    if (do_pop) begin
      exp_pc = exp_pc + 32'd4;
      occ--;
    end
    if (do_push) occ++;
    if (exp_req && g) begin
      mq.push_back('{addr: fa, due: cyc + lat, drop: 1'b0, counted: 1'b1});
      fa = fa + 32'd4;
    end
    if (br && !r) begin
      foreach (mq[i]) mq[i].drop = 1'b1;
      occ = 0; fa = tgt; exp_pc = tgt;
    end
    if (r) begin
      foreach (mq[i]) begin mq[i].drop = 1'b1; mq[i].counted = 1'b0; end
      occ = 0; fa = RESET_PC; exp_pc = RESET_PC; n_pop = 0; n_bub = 0;
    end
    @(posedge clk);
    cyc++;
  endtask

  // Reset while the memory still owes words: wait until they have all drained.
  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 30 && mq.size() > 0; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    int first = -1;
    logic [31:0] pc2 = '1, pc3 = '1;
    lat = 1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 1);
      if (i == 0) begin
        total++;
        if (s_valid !== 1'b0 || s_pc !== 32'h0 || s_inst !== NOP) begin
          bad++; $display("FAIL reset_outputs got=%b/%h/%h exp=0/0/%h", s_valid, s_pc, s_inst, NOP);
        end
      end
      if (first < 0 && s_valid) first = i;
      if (i == 2) pc2 = s_pc;
      if (i == 3) pc3 = s_pc;
    end
    total++;
    if (first != 2 || pc2 !== 32'h0 || pc3 !== 32'h4) begin
      bad++; $display("FAIL first_fetch got=%0d/%h/%h exp=2/0/4", first, pc2, pc3);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held = '0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 1);
      if (i == 0) held = s_pc;
    end
    total++;
    if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== held) begin
      bad++; $display("FAIL stall_hold got=%b/%b/%h exp=0/1/%h", s_req, s_valid, s_pc, held);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic first_valid_after(input logic [31:0] want, input string name);
    int first = -1;
    logic [31:0] fpc = '0;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 0, 1);
      if (first < 0 && s_valid) begin first = i; fpc = s_pc; end
    end
    total++;
    if (first < 0 || fpc !== want) begin
      bad++; $display("FAIL %s got=%h (cycle %0d) exp=%h", name, fpc, first, want);
    end
  endtask

  task automatic test_branch_late();
    do_reset();
    lat = 3;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h100, 1);
    first_valid_after(32'h100, "branch_late");
  endtask

  task automatic test_branch_rvalid();
    do_reset();
    lat = 2;
    for (int i = 0; i < 10 && !resp_now(); i++) step(0, 0, 0, 0, 1);
    total++;
    if (!resp_now()) begin
      bad++; $display("FAIL branch_rvalid_setup got=no_response exp=response");
    end
    step(0, 0, 1, 32'h100, 1);
    first_valid_after(32'h100, "branch_rvalid");
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 3;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h200, 1);
    step(0, 0, 1, 32'h300, 1);
    first_valid_after(32'h300, "back_to_back");
  endtask

  task automatic test_gnt_hold();
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      total++;
      if (s_addr !== RESET_PC || s_valid !== 1'b0 || s_inst !== NOP) begin
        bad++; $display("FAIL gnt_hold got=%h/%b/%h exp=%h/0/%h", s_addr, s_valid, s_inst, RESET_PC, NOP);
      end
    end
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    total++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      bad++; $display("FAIL pc_wrap got=%b/%h exp=1/0", s_req, s_addr);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    lat = 4;
    step(0, 0, 1, 32'h40, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      total++;
      if (s_valid !== 1'b0) begin
        bad++; $display("FAIL stale_after_reset got=%b exp=0", s_valid);
      end
    end
    lat = 1;
    first_valid_after(RESET_PC, "resume_after_reset");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      step(0, ($urandom % 4) == 0, ($urandom % 32) == 0, $urandom & 32'hFFFF_FFFC, ($urandom % 4) != 0);
    end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    int bub;
    do_reset();
    lat = 1;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 60 && n_pop < 10; i++) step(0, 0, 0, 0, 1);
    bub = n_bub;
    step(0, 1, 0, 0, 1);
    total++;
    if (s_pf !== 32'd10 || s_pb !== 32'(bub) || bub < 3) begin
      bad++; $display("FAIL perf_counts got=%0d/%0d exp=10/%0d", s_pf, s_pb, bub);
    end
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    total++;
    if (s_pf !== 32'd0 || s_pb !== 32'd0) begin
      bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", s_pf, s_pb);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stall();
    test_branch_late();
    test_branch_rvalid();
    test_back_to_back();
    test_gnt_hold();
    test_reset_mid();
    test_random();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
